mac_engine: RTL
===============

Name: mac_engine

Overview:
- Streaming multiply-accumulate datapath of the MAC HWPE.
- Sits directly downstream of the streamer sources (a, b, c) and directly upstream of the streamer sink (d).
- Driven by the controller FSM through a ctrl_engine_t bundle; reports progress back through a flags_engine_t bundle.
- Two modes, both for signed 32-bit operands:
  - simple_mul: one result per a/b pair.
  - accumulate: one result per run of len pairs, seeded with c.

Parameters:
- CNT_LEN, default MAC_CNT_LEN (1024): maximum run length; counters are $clog2(CNT_LEN)+1 bits wide.
- DATA_W, default 32: width of a, b, c and d.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- a_data_i  in  DATA_W  operand a, signed.
- a_valid_i  in  1  a valid.
- a_ready_o  out  1  a ready.
- b_data_i  in  DATA_W  operand b, signed.
- b_valid_i  in  1  b valid.
- b_ready_o  out  1  b ready.
- c_data_i  in  DATA_W  accumulator seed, signed.
- c_valid_i  in  1  c valid.
- c_ready_o  out  1  c ready.
- d_data_o  out  DATA_W  result.
- d_valid_o  out  1  result valid.
- d_ready_i  in  1  sink ready.
- ctrl_i  in  ctrl_engine_t (20 bits)  clear, enable, simple_mul, start, shift[4:0], len[10:0].
- flags_o  out  flags_engine_t (12 bits)  cnt[10:0], acc_valid.

Behaviour:
- Reset (rst_i high, async): all registers 0. d_valid_o=0, d_data_o=0, flags_o=0, all ready outputs 0.
- ctrl_i.clear: synchronous equivalent of reset; takes priority over all other inputs.
- ctrl_i.start: one-cycle pulse.
  - Latches simple_mul, shift and len into config registers; len==0 is latched as 1.
  - Flushes stage1, stage2, accumulator and counters in the same edge.
  - No handshake is accepted in the start cycle.
- ctrl_i.enable=0: all ready outputs are 0, d_valid_o holds its value, no state changes.
- Input handshake (fire):
  - need_c = !simple_mul && in_cnt==0.
  - fire = enable && a_valid && b_valid && (c_valid || !need_c) && s1_free.
  - a_ready_o = b_ready_o = fire. c_ready_o = fire && need_c.
  - Ready outputs never depend combinationally on their own valid beyond this expression.
- Stage 1 (registered):
  - prod = a*b as signed 64-bit; term = prod >>> shift (arithmetic).
  - Stores term[DATA_W-1:0], the first flag (need_c), the last flag (in_cnt==len-1), and c.
  - in_cnt increments per fire and wraps to 0 after len-1.
- Stage 2:
  - Advances when s1 is full and (!d_valid_o || d_ready_i).
  - s1_free = !s1_full || stage-2 advance.
  - simple_mul: d_data_o <= term; d_valid_o <= 1.
  - accumulate: acc <= (first ? c : acc) + term, with two's-complement wrap; cnt increments.
    - On last: d_data_o <= new acc, d_valid_o <= 1, cnt resets to 0 on the following advance.
- d_valid_o clears on d_ready_i unless a new result is written in the same cycle.
- Latency and throughput:
  - Handshake at cycle t gives d_valid_o at t+2 (simple_mul), or t+2 after the last pair (accumulate).
  - Full throughput is 1 pair/cycle while d_ready_i stays high.
- Back-pressure:
  - d_valid_o=1 with d_ready_i=0 stalls stage 2.
  - Stage 1 then stays full and all input readies drop.
  - No data is lost or duplicated.
- flags_o.cnt: pairs accumulated in the current run. It is 0 in simple_mul.
- flags_o.acc_valid = d_valid_o && !simple_mul.

Optional Feature:
- Macro: MAC_ENGINE_SATURATE_EN.
- Defined:
  - The stage-1 term saturates to signed DATA_W range instead of truncating.
  - The accumulator add saturates to [-2^31, 2^31-1].
- Undefined: plain truncation and two's-complement wrap, as above.

Decomposition:
- Package mac_package holds:
  - ctrl_engine_t, flags_engine_t, MAC_CNT_LEN.
  - A new localparam MAC_DATA_W=32.
- Sub-module mac_engine_mult: stage-1 register holding the signed multiply, shift and optional saturation, with valid/stall inputs.
- Handshake logic, counters and stage 2 stay in mac_engine.

Test Plan:
- Reset mid-run (rst_i pulse after 3 of 8 pairs) -> all outputs 0 immediately. After start with len=2, accumulate a={1,2}, b={3,4}, c=0 -> d=11.
- simple_mul, shift=0, a=-3, b=7, d_ready_i=1, pairs streamed back-to-back -> d=-21 two cycles after handshake, one result per cycle.
- accumulate, len=4, shift=1, c=100, a={2,4,6,8}, b=1 -> exactly one d=110; acc_valid=1 with it; cnt steps 1,2,3,4.
- Back-pressure: simple_mul, 4 pairs, d_ready_i low for 5 cycles -> readies drop after stage 1 fills; results 1..4 emerge in order once d_ready_i rises.
- len=0 with two runs -> treated as len=1; d = c+term per pair, and c is consumed every pair.
- With MAC_ENGINE_SATURATE_EN: a=b=0x7FFFFFFF, shift=0 -> d=0x7FFFFFFF. Without the macro: d=0x00000001.

Source files
------------

// File: rtl/mac_engine_pkg.sv
// Shared types and constants for the MAC engine: the control bundle from the
// controller FSM, the progress flags returned to it, and default sizes.
package mac_package;

  localparam int MAC_CNT_LEN = 1024;
  localparam int MAC_DATA_W  = 32;

  typedef struct packed {
    logic        clear;
    logic        enable;
    logic        simple_mul;
    logic        start;
    logic [4:0]  shift;
    logic [10:0] len;
  } ctrl_engine_t;

  typedef struct packed {
    logic [10:0] cnt;
    logic        acc_valid;
  } flags_engine_t;

endpackage

// File: rtl/mac_engine_mult.sv
// Stage-1 register of the MAC engine: signed multiply, arithmetic right shift
// and narrowing to DATA_W, plus the first/last/seed sideband of the pair.
// Build option MAC_ENGINE_SATURATE_EN clamps the narrowed term to the signed
// DATA_W range; otherwise the upper bits are simply dropped.
module mac_engine_mult
  import mac_package::*;
#(
  parameter int DATA_W = MAC_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] c_i,
  input  logic              first_i,
  input  logic              last_i,
  input  logic [4:0]        shift_i,
  output logic              full_o,
  output logic [DATA_W-1:0] term_o,
  output logic [DATA_W-1:0] c_o,
  output logic              first_o,
  output logic              last_o
);

  logic signed [2*DATA_W-1:0] a_ext;
  logic signed [2*DATA_W-1:0] b_ext;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [2*DATA_W-1:0] shifted;
  logic        [DATA_W-1:0]   term;

  assign a_ext   = {{DATA_W{a_i[DATA_W-1]}}, a_i};
  assign b_ext   = {{DATA_W{b_i[DATA_W-1]}}, b_i};
  assign prod    = a_ext * b_ext;
  assign shifted = prod >>> shift_i;

`ifdef MAC_ENGINE_SATURATE_EN
  logic [DATA_W:0] upper;
  assign upper = shifted[2*DATA_W-1:DATA_W-1];

  // Narrow the shifted product, clamping when the upper bits are not a pure sign extension.
  always_comb begin
    term = shifted[DATA_W-1:0];
    if (!((&upper) || !(|upper))) begin
      term = shifted[2*DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  assign term = shifted[DATA_W-1:0];
`endif

  // Pipeline register: loads on a handshake, empties when stage 2 takes it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_o  <= 1'b0;
      term_o  <= '0;
      c_o     <= '0;
      first_o <= 1'b0;
      last_o  <= 1'b0;
    end else if (flush_i) begin
      full_o  <= 1'b0;
      term_o  <= '0;
      c_o     <= '0;
      first_o <= 1'b0;
      last_o  <= 1'b0;
    end else if (valid_i) begin
      full_o  <= 1'b1;
      term_o  <= term;
      c_o     <= c_i;
      first_o <= first_i;
      last_o  <= last_i;
    end else if (pop_i) begin
      full_o  <= 1'b0;
    end
  end

endmodule

// File: rtl/mac_engine.sv
// Streaming multiply-accumulate datapath between the a/b/c streamer sources
// and the d sink. Two-stage pipeline: stage 1 (mac_engine_mult) multiplies and
// shifts, stage 2 either forwards the term (simple_mul) or accumulates a run
// of len terms seeded with c. Build option MAC_ENGINE_SATURATE_EN makes the
// accumulator add saturate instead of wrapping.
module mac_engine
  import mac_package::*;
#(
  parameter int CNT_LEN = MAC_CNT_LEN,
  parameter int DATA_W  = MAC_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [DATA_W-1:0] b_data_i,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic [DATA_W-1:0] c_data_i,
  input  logic              c_valid_i,
  output logic              c_ready_o,
  output logic [DATA_W-1:0] d_data_o,
  output logic              d_valid_o,
  input  logic              d_ready_i,
  input  ctrl_engine_t      ctrl_i,
  output flags_engine_t     flags_o
);

  localparam int CNT_W  = $clog2(CNT_LEN) + 1;
  localparam int FCNT_W = $bits(flags_engine_t) - 1;

  logic              cfg_simple_mul;
  logic [4:0]        cfg_shift;
  logic [CNT_W-1:0]  cfg_len;
  logic [CNT_W-1:0]  in_cnt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc;

  logic              s1_full;
  logic              s1_first;
  logic              s1_last;
  logic [DATA_W-1:0] s1_term;
  logic [DATA_W-1:0] s1_c;

  logic              flush;
  logic              active;
  logic              need_c;
  logic              in_last;
  logic              adv;
  logic              s1_free;
  logic              fire;
  logic              wr_out;
  logic [DATA_W-1:0] acc_base;
  logic [DATA_W:0]   acc_sum;
  logic [DATA_W-1:0] acc_next;

  // Start and clear both empty the pipeline; neither admits a handshake.
  assign flush   = ctrl_i.clear | ctrl_i.start;
  assign active  = ctrl_i.enable & ~flush & ~rst_i;
  assign need_c  = ~cfg_simple_mul & (in_cnt == '0);
  assign in_last = (in_cnt == cfg_len - CNT_W'(1));
  assign adv     = active & s1_full & (~d_valid_o | d_ready_i);
  assign s1_free = ~s1_full | adv;
  assign fire    = active & a_valid_i & b_valid_i & (c_valid_i | ~need_c) & s1_free;

  assign a_ready_o = fire;
  assign b_ready_o = fire;
  assign c_ready_o = fire & need_c;

  assign wr_out   = adv & (cfg_simple_mul | s1_last);
  assign acc_base = s1_first ? s1_c : acc;
  assign acc_sum  = {acc_base[DATA_W-1], acc_base} + {s1_term[DATA_W-1], s1_term};

`ifdef MAC_ENGINE_SATURATE_EN
  // Clamp on signed overflow: the carry-out sign disagrees with the result sign.
  always_comb begin
    acc_next = acc_sum[DATA_W-1:0];
    if (acc_sum[DATA_W] != acc_sum[DATA_W-1]) begin
      acc_next = acc_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  assign acc_next = acc_sum[DATA_W-1:0];
`endif

  assign flags_o.cnt       = FCNT_W'(cnt);
  assign flags_o.acc_valid = d_valid_o & ~cfg_simple_mul;

  // Run configuration, captured on start; a zero length runs as length 1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_simple_mul <= 1'b0;
      cfg_shift      <= '0;
      cfg_len        <= '0;
    end else if (ctrl_i.clear) begin
      cfg_simple_mul <= 1'b0;
      cfg_shift      <= '0;
      cfg_len        <= '0;
    end else if (ctrl_i.start) begin
      cfg_simple_mul <= ctrl_i.simple_mul;
      cfg_shift      <= ctrl_i.shift;
      cfg_len        <= (ctrl_i.len == '0) ? CNT_W'(1) : CNT_W'(ctrl_i.len);
    end
  end

  // Input pair counter: position of the next pair within its run.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      in_cnt <= '0;
    end else if (flush) begin
      in_cnt <= '0;
    end else if (fire) begin
      in_cnt <= in_last ? '0 : in_cnt + CNT_W'(1);
    end
  end

  mac_engine_mult #(
    .DATA_W (DATA_W)
  ) u_mult (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush),
    .valid_i (fire),
    .pop_i   (adv),
    .a_i     (a_data_i),
    .b_i     (b_data_i),
    .c_i     (c_data_i),
    .first_i (need_c),
    .last_i  (in_last),
    .shift_i (cfg_shift),
    .full_o  (s1_full),
    .term_o  (s1_term),
    .c_o     (s1_c),
    .first_o (s1_first),
    .last_o  (s1_last)
  );

  // Stage 2: accumulate or forward, and hold the result until the sink takes it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc       <= '0;
      cnt       <= '0;
      d_data_o  <= '0;
      d_valid_o <= 1'b0;
    end else if (flush) begin
      acc       <= '0;
      cnt       <= '0;
      d_data_o  <= '0;
      d_valid_o <= 1'b0;
    end else if (ctrl_i.enable) begin
      if (adv && !cfg_simple_mul) begin
        acc <= acc_next;
        cnt <= s1_first ? CNT_W'(1) : cnt + CNT_W'(1);
      end
      if (wr_out) begin
        d_data_o  <= cfg_simple_mul ? s1_term : acc_next;
        d_valid_o <= 1'b1;
      end else if (d_ready_i) begin
        d_valid_o <= 1'b0;
      end
    end
  end

endmodule
